// File: rtl/pc_counter_pkg.sv
// rtl/pc_counter_pkg.sv - default widths, step and reset value for the pc_counter block
package pc_counter_pkg;

    localparam int PC_WIDTH_DEF = 4;
    localparam int PC_STEP_DEF  = 1;
    localparam int PC_RST_DEF   = 0;

    typedef logic [PC_WIDTH_DEF-1:0] pc_t;

endpackage

// File: rtl/pc_counter_inc.sv
// rtl/pc_counter_inc.sv - combinational +STEP adder with carry; PC_COUNTER_SATURATE_EN clamps at max
module pc_counter_inc
    import pc_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int STEP  = PC_STEP_DEF
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH:0] sum_full;

    assign sum_full = {1'b0, cur} + STEP_W;
    assign carry    = sum_full[WIDTH];

`ifdef PC_COUNTER_SATURATE_EN
    // STEP >= 1, so a count attempt from the maximum always carries and clamps
    assign sum = carry ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    assign sum = sum_full[WIDTH-1:0];
`endif

endmodule

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program-counter up counter with load and wrap flag (option: PC_COUNTER_SATURATE_EN)
module pc_counter
    import pc_counter_pkg::*;
#(
    parameter int WIDTH   = PC_WIDTH_DEF,
    parameter int STEP    = PC_STEP_DEF,
    parameter int RST_VAL = PC_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] pcounter,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] inc_sum;
    logic             inc_carry;

    pc_counter_inc #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_inc (
        .cur   (pcounter),
        .sum   (inc_sum),
        .carry (inc_carry)
    );

    // Load outranks enable; wrap only ever reflects the count made on the previous edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcounter <= RST_V;
            wrap     <= 1'b0;
        end else if (ld) begin
            pcounter <= ld_val;
            wrap     <= 1'b0;
        end else if (en) begin
            pcounter <= inc_sum;
            wrap     <= inc_carry;
        end else begin
            wrap     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_counter.sv
// tb/tb_pc_counter.sv - randomized self-checking bench for pc_counter (STEP=1 and STEP=3 instances)
module tb_pc_counter;

    logic       clk;
    logic       reset;
    logic       en, ld, en3, ld3;
    logic [3:0] ld_val, ld_val3;
    logic [3:0] pcounter, pcounter3;
    logic       wrap, wrap3;

    int errors = 0;
    int checks = 0;

    int unsigned m_pc, m_wrap, m3_pc, m3_wrap;

    pc_counter dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ld       (ld),
        .ld_val   (ld_val),
        .pcounter (pcounter),
        .wrap     (wrap)
    );

    pc_counter #(.WIDTH(4), .STEP(3), .RST_VAL(0)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .en       (en3),
        .ld       (ld3),
        .ld_val   (ld_val3),
        .pcounter (pcounter3),
        .wrap     (wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic against a 16-value range
    task automatic model(inout int unsigned pc, inout int unsigned wr,
                         input int unsigned step, input bit l, input bit e,
                         input int unsigned lv);
        int unsigned s;
        if (l) begin
            pc = lv;
            wr = 0;
        end else if (e) begin
            s  = pc + step;
            wr = (s > 15) ? 1 : 0;
`ifdef PC_COUNTER_SATURATE_EN
            pc = (s > 15) ? 15 : s;
`else
            pc = s % 16;
`endif
        end else begin
            wr = 0;
        end
    endtask

    task automatic apply(input bit l, input bit e, input int unsigned lv,
                         input bit l3, input bit e3, input int unsigned lv3);
        ld = l; en = e; ld_val = 4'(lv);
        ld3 = l3; en3 = e3; ld_val3 = 4'(lv3);
        @(posedge clk);
        #1;
        model(m_pc, m_wrap, 1, l, e, lv);
        model(m3_pc, m3_wrap, 3, l3, e3, lv3);
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 1'b1; ld = 1'b0; ld_val = '0;
        en3 = 1'b1; ld3 = 1'b0; ld_val3 = '0;
        m_pc = 0; m_wrap = 0; m3_pc = 0; m3_wrap = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pcounter !== 4'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pcounter); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0d expected 0", wrap); end
        checks++; if (pcounter3 !== 4'd0) begin errors++; $display("FAIL reset_pc3: got %0d expected 0", pcounter3); end
        checks++; if (wrap3 !== 1'b0) begin errors++; $display("FAIL reset_wrap3: got %0d expected 0", wrap3); end
        en = 1'b0; en3 = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic test_count;
        for (int i = 1; i <= 3; i++) begin
            apply(0, 1, 0, 0, 0, 0);
            checks++; if (pcounter !== 4'(i)) begin errors++; $display("FAIL count_pc: got %0d expected %0d", pcounter, i); end
            checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL count_wrap: got %0d expected 0", wrap); end
        end
    endtask

    task automatic test_wrap;
        apply(1, 0, 14, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, (i < 2), 0, 0, 0, 0);
            checks++; if (pcounter !== 4'(m_pc)) begin errors++; $display("FAIL wrap_pc: got %0d expected %0d", pcounter, m_pc); end
            checks++; if (wrap !== 1'(m_wrap)) begin errors++; $display("FAIL wrap_flag: got %0d expected %0d", wrap, m_wrap); end
        end
    endtask

    task automatic test_load_priority;
        apply(1, 1, 9, 0, 0, 0);
        checks++; if (pcounter !== 4'd9) begin errors++; $display("FAIL load_pc: got %0d expected 9", pcounter); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_wrap: got %0d expected 0", wrap); end
        apply(0, 1, 0, 0, 0, 0);
        checks++; if (pcounter !== 4'd10) begin errors++; $display("FAIL load_next_pc: got %0d expected 10", pcounter); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_next_wrap: got %0d expected 0", wrap); end
    endtask

    task automatic test_hold;
        apply(1, 0, 6, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            checks++; if (pcounter !== 4'd6) begin errors++; $display("FAIL hold_pc: got %0d expected 6", pcounter); end
            checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap: got %0d expected 0", wrap); end
        end
    endtask

    task automatic test_async_reset;
        apply(1, 0, 5, 0, 0, 0);
        checks++; if (pcounter !== 4'd5) begin errors++; $display("FAIL areset_pre: got %0d expected 5", pcounter); end
        #2 reset = 1'b0;
        #1;
        m_pc = 0; m_wrap = 0; m3_pc = 0; m3_wrap = 0;
        checks++; if (pcounter !== 4'd0) begin errors++; $display("FAIL areset_pc: got %0d expected 0", pcounter); end
        #1 reset = 1'b1;
        apply(0, 1, 0, 0, 0, 0);
        checks++; if (pcounter !== 4'd1) begin errors++; $display("FAIL areset_resume: got %0d expected 1", pcounter); end
        apply(0, 1, 0, 0, 0, 0);
        checks++; if (pcounter !== 4'd2) begin errors++; $display("FAIL areset_resume2: got %0d expected 2", pcounter); end
    endtask

    task automatic test_step3;
        apply(0, 0, 0, 1, 0, 12);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, (i < 2), 0);
            checks++; if (pcounter3 !== 4'(m3_pc)) begin errors++; $display("FAIL step3_pc: got %0d expected %0d", pcounter3, m3_pc); end
            checks++; if (wrap3 !== 1'(m3_wrap)) begin errors++; $display("FAIL step3_wrap: got %0d expected %0d", wrap3, m3_wrap); end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 15));
            checks++; if (pcounter !== 4'(m_pc)) begin errors++; $display("FAIL rand_pc: cycle %0d got %0d expected %0d", i, pcounter, m_pc); end
            checks++; if (wrap !== 1'(m_wrap)) begin errors++; $display("FAIL rand_wrap: cycle %0d got %0d expected %0d", i, wrap, m_wrap); end
            checks++; if (pcounter3 !== 4'(m3_pc)) begin errors++; $display("FAIL rand_pc3: cycle %0d got %0d expected %0d", i, pcounter3, m3_pc); end
            checks++; if (wrap3 !== 1'(m3_wrap)) begin errors++; $display("FAIL rand_wrap3: cycle %0d got %0d expected %0d", i, wrap3, m3_wrap); end
        end
    endtask

    initial begin
        test_reset;
        test_count;
        test_wrap;
        test_load_priority;
        test_hold;
        test_async_reset;
        test_step3;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
